vga_text_buffer: RTL and testbench

//   Parametrised text-mode video memory between the PS/2 keyboard decoder and the VGA glyph ROM.

---
 rtl/vga_text_pkg.sv | 20 ++
 rtl/text_ram.sv | 22 ++
 rtl/vga_text_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_vga_text_buffer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text buffer: FSM states, ASCII codes, default geometry.
package vga_text_pkg;

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

  localparam logic [7:0] ENTER      = 8'h0A;
  localparam logic [7:0] CR         = 8'h0D;
  localparam logic [7:0] BS         = 8'h08;
  localparam logic [7:0] UNDERSCORE = 8'h5F;

  localparam int DEF_COLS   = 70;
  localparam int DEF_ROWS   = 30;
  localparam int DEF_CHAR_W = 9;
  localparam int DEF_CHAR_H = 16;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
module text_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2100,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_text_buffer.sv
// Text-mode video memory with cursor, line wrap and ring-of-rows scrolling.
// Optional blinking underscore cursor when TEXT_CURSOR_BLINK_EN is defined.
module vga_text_buffer
  import vga_text_pkg::*;
#(
  parameter int         COLS   = DEF_COLS,
  parameter int         ROWS   = DEF_ROWS,
  parameter int         CHAR_W = DEF_CHAR_W,
  parameter int         CHAR_H = DEF_CHAR_H,
  parameter logic [7:0] BLANK  = 8'h00
`ifdef TEXT_CURSOR_BLINK_EN
  ,
  parameter int         BLINK_CYCLES = 25_000_000
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                key_in,
  input  logic                      key_valid,
  output logic                      key_ready,
  input  logic [9:0]                h_addr,
  input  logic [9:0]                v_addr,
  output logic [7:0]                ascii_out,
  output logic [3:0]                glyph_row,
  output logic [3:0]                glyph_col,
  output logic [$clog2(COLS)-1:0]   cur_x,
  output logic [$clog2(ROWS)-1:0]   cur_y
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);

  // Physical rows form a ring starting at top, so screen line y lives in row (top+y) mod ROWS.
  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] top_r,
                                              input logic [YW-1:0] y,
                                              input logic [XW-1:0] x);
    int row;
    row = int'(top_r) + int'(y);
    if (row >= ROWS) row = row - ROWS;
    return AW'(row * COLS + int'(x));
  endfunction

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   clr_base;
  logic [YW-1:0]   top;

  logic            accept, printable, bs_move, do_nl;
  logic [XW-1:0]   bs_x;
  logic [YW-1:0]   bs_y;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;

  assign key_ready = (state == IDLE);
  assign accept    = key_valid && key_ready;

  always_comb begin
    printable = is_printable(key_in);
    bs_move   = (key_in == BS) && ((cur_x != '0) || (cur_y != '0));
    do_nl     = accept && ((printable && (cur_x == XW'(COLS - 1))) ||
                           (key_in == ENTER) || (key_in == CR));
    bs_x      = (cur_x != '0) ? cur_x - 1'b1 : XW'(COLS - 1);
    bs_y      = (cur_x != '0) ? cur_y : cur_y - 1'b1;
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = BLANK;
    unique case (state)
      CLR_ALL: begin
        we    = 1'b1;
        waddr = clr_cnt;
      end
      CLR_LINE: begin
        we    = 1'b1;
        waddr = clr_base + clr_cnt;
      end
      default: begin
        if (accept && printable) begin
          we    = 1'b1;
          waddr = cell_addr(top, cur_y, cur_x);
          wdata = key_in;
        end else if (accept && bs_move) begin
          we    = 1'b1;
          waddr = cell_addr(top, bs_y, bs_x);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLR_ALL;
      clr_cnt  <= '0;
      clr_base <= '0;
      top      <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
    end else begin
      unique case (state)
        CLR_ALL: begin
          if (clr_cnt == AW'(CELLS - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        CLR_LINE: begin
          if (clr_cnt == AW'(COLS - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            if (printable) begin
              cur_x <= (cur_x == XW'(COLS - 1)) ? '0 : cur_x + 1'b1;
            end else if ((key_in == ENTER) || (key_in == CR)) begin
              cur_x <= '0;
            end else if (bs_move) begin
              cur_x <= bs_x;
              cur_y <= bs_y;
            end
          end
          // At the bottom line, scrolling advances the ring; the old top row becomes the new bottom.
          if (do_nl) begin
            if (cur_y != YW'(ROWS - 1)) begin
              cur_y <= cur_y + 1'b1;
            end else begin
              top      <= (top == YW'(ROWS - 1)) ? '0 : top + 1'b1;
              clr_base <= AW'(int'(top) * COLS);
              clr_cnt  <= '0;
              state    <= CLR_LINE;
            end
          end
        end
      endcase
    end
  end

  // Read stage p0: pixel address to cell address, independent of the write port.
  int            cx_int, cy_int;
  logic          in_range;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata_p1;
  logic          in_range_p1;

  always_comb begin
    cx_int   = int'(h_addr) / CHAR_W;
    cy_int   = int'(v_addr) / CHAR_H;
    in_range = (cx_int < COLS) && (cy_int < ROWS);
    raddr    = in_range ? cell_addr(top, YW'(cy_int), XW'(cx_int)) : '0;
  end

  text_ram #(.DATA_W(8), .DEPTH(CELLS), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata_p1)
  );

  // Read stage p1: registered glyph coordinates and range flag aligned with RAM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_range_p1 <= 1'b0;
      glyph_row   <= '0;
      glyph_col   <= '0;
    end else begin
      in_range_p1 <= in_range;
      glyph_row   <= 4'(int'(v_addr) % CHAR_H);
      glyph_col   <= 4'(int'(h_addr) % CHAR_W);
    end
  end

`ifdef TEXT_CURSOR_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic          hit_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      hit_p1    <= 1'b0;
    end else begin
      hit_p1 <= in_range && (cx_int == int'(cur_x)) && (cy_int == int'(cur_y));
      if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign ascii_out = (hit_p1 && blink_on) ? UNDERSCORE :
                     in_range_p1          ? rdata_p1   : BLANK;
`else
  assign ascii_out = in_range_p1 ? rdata_p1 : BLANK;
`endif

endmodule

// File: tb/tb_vga_text_buffer.sv
// Randomised bench for vga_text_buffer against a row-shifting screen model.
module tb_vga_text_buffer;

  localparam int COLS = 70;
  localparam int ROWS = 30;
  localparam int CW   = 9;
  localparam int CH   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [9:0] h_addr, v_addr;
  logic [7:0] ascii_out;
  logic [3:0] glyph_row, glyph_col;
  logic [6:0] cur_x;
  logic [4:0] cur_y;

  int total  = 0;
  int passed = 0;

  logic [7:0] scr [ROWS][COLS];
  logic [7:0] got [ROWS][COLS];
  int mx, my;

  vga_text_buffer dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .h_addr(h_addr), .v_addr(v_addr),
    .ascii_out(ascii_out), .glyph_row(glyph_row), .glyph_col(glyph_col),
    .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    mx = 0;
    my = 0;
  endtask

  task automatic model_newline();
    if (my < ROWS - 1) begin
      my++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
    end
  endtask

  task automatic model_key(input logic [7:0] k);
    if (k >= 8'h20 && k <= 8'h7E) begin
      scr[my][mx] = k;
      if (mx == COLS - 1) begin
        mx = 0;
        model_newline();
      end else begin
        mx++;
      end
    end else if (k == 8'h0A || k == 8'h0D) begin
      mx = 0;
      model_newline();
    end else if (k == 8'h08) begin
      if (mx > 0) begin
        mx--;
        scr[my][mx] = 8'h00;
      end else if (my > 0) begin
        mx = COLS - 1;
        my--;
        scr[my][mx] = 8'h00;
      end
    end
  endtask

  function automatic logic [7:0] exp_cell(input int c, input int r);
`ifdef TEXT_CURSOR_BLINK_EN
    if (c == mx && r == my) return 8'h5F;
`endif
    return scr[r][c];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!key_ready && n < 5000);
  endtask

  task automatic send_key(input logic [7:0] k);
    int n;
    n = 0;
    while (!key_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!key_ready) begin
      total++;
      $display("FAIL key_ready_timeout got=%0b want=1", key_ready);
    end
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_in    = $urandom_range(255);
    model_key(k);
  endtask

  task automatic read_cell(input int c, input int r, output logic [7:0] a,
                           output logic [3:0] gc, output logic [3:0] gr,
                           output int h, output int v);
    h = c * CW + $urandom_range(CW - 1);
    v = r * CH + $urandom_range(CH - 1);
    h_addr = 10'(h);
    v_addr = 10'(v);
    @(posedge clk); #1;
    a  = ascii_out;
    gc = glyph_col;
    gr = glyph_row;
  endtask

  task automatic capture_screen();
    logic [7:0] a;
    logic [3:0] gc, gr;
    int h, v;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(c, r, a, gc, gr, h, v);
        got[r][c] = a;
      end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n, bad, br, bc;
    reset = 1'b1; key_valid = 1'b0; key_in = 8'h00;
    h_addr = 10'd5; v_addr = 10'd7;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (key_ready !== 1'b0 || cur_x !== 7'd0 || cur_y !== 5'd0 || ascii_out !== 8'h00 ||
        glyph_row !== 4'd0 || glyph_col !== 4'd0)
      $display("FAIL reset_state got rdy=%0b x=%0d y=%0d a=%h gr=%0d gc=%0d want 0 0 0 00 0 0",
               key_ready, cur_x, cur_y, ascii_out, glyph_row, glyph_col);
    else passed++;
    reset = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    do_reset();
    wait_ready(n);
    total++;
    if (n !== 2099 + 1) $display("FAIL clear_all_cycles got=%0d want=%0d", n, COLS * ROWS);
    else passed++;
    capture_screen();
    bad = 0; br = 0; bc = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (got[r][c] !== exp_cell(c, r)) begin
          if (bad == 0) begin br = r; bc = c; end
          bad++;
        end
    total++;
    if (bad != 0) $display("FAIL cleared_screen bad_cells=%0d first(%0d,%0d) got=%h want=%h",
                           bad, bc, br, got[br][bc], exp_cell(bc, br));
    else passed++;
  endtask

  task automatic test_print();
    logic [7:0] a;
    logic [3:0] gc, gr;
    send_key(8'h41);
    send_key(8'h42);
    total++;
    if (cur_x !== 7'd2 || cur_y !== 5'd0) $display("FAIL print_cursor got=(%0d,%0d) want=(2,0)", cur_x, cur_y);
    else passed++;
    h_addr = 10'd9; v_addr = 10'd0;
    @(posedge clk); #1;
    a = ascii_out; gc = glyph_col; gr = glyph_row;
    total++;
    if (a !== 8'h42 || gc !== 4'd0 || gr !== 4'd0)
      $display("FAIL print_read got a=%h gc=%0d gr=%0d want a=42 gc=0 gr=0", a, gc, gr);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] a;
    logic [3:0] gc, gr;
    int h, v;
    send_key(8'h0D);
    for (int i = 0; i < COLS; i++) send_key(8'h78);
    total++;
    if (cur_x !== 7'd0 || cur_y !== 5'd2) $display("FAIL wrap_cursor got=(%0d,%0d) want=(0,2)", cur_x, cur_y);
    else passed++;
    send_key(8'h79);
    read_cell(0, 2, a, gc, gr, h, v);
    total++;
    if (a !== 8'h79 || gc !== 4'(h % CW) || gr !== 4'(v % CH))
      $display("FAIL wrap_71st got a=%h gc=%0d gr=%0d want a=79 gc=%0d gr=%0d", a, gc, gr, h % CW, v % CH);
    else passed++;
    read_cell(COLS - 1, 1, a, gc, gr, h, v);
    total++;
    if (a !== 8'h78) $display("FAIL wrap_last_col got=%h want=78", a);
    else passed++;
  endtask

  task automatic test_scroll();
    int n, bad, br, bc;
    while (my < ROWS - 1) begin
      send_key(8'($urandom_range(126, 33)));
      send_key(8'h0A);
    end
    send_key(8'h51);
    while (!key_ready) begin @(posedge clk); #1; end
    key_in = 8'h0A; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    model_key(8'h0A);
    total++;
    if (key_ready !== 1'b0) $display("FAIL scroll_ready_drop got=%0b want=0", key_ready);
    else passed++;
    n = 0;
    while (!key_ready && n < 500) begin @(posedge clk); #1; n++; end
    total++;
    if (n !== COLS) $display("FAIL scroll_busy_cycles got=%0d want=%0d", n, COLS);
    else passed++;
    total++;
    if (cur_x !== 7'd0 || cur_y !== 5'(ROWS - 1))
      $display("FAIL scroll_cursor got=(%0d,%0d) want=(0,%0d)", cur_x, cur_y, ROWS - 1);
    else passed++;
    capture_screen();
    bad = 0; br = 0; bc = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (got[r][c] !== exp_cell(c, r)) begin
          if (bad == 0) begin br = r; bc = c; end
          bad++;
        end
    total++;
    if (bad != 0) $display("FAIL scroll_screen bad_cells=%0d first(%0d,%0d) got=%h want=%h",
                           bad, bc, br, got[br][bc], exp_cell(bc, br));
    else passed++;
  endtask

  task automatic test_oob();
    h_addr = 10'd640; v_addr = 10'd0;
    @(posedge clk); #1;
    total++;
    if (ascii_out !== 8'h00 || glyph_col !== 4'd1)
      $display("FAIL oob_col got a=%h gc=%0d want a=00 gc=1", ascii_out, glyph_col);
    else passed++;
    h_addr = 10'd0; v_addr = 10'd480;
    @(posedge clk); #1;
    total++;
    if (ascii_out !== 8'h00 || glyph_row !== 4'd0)
      $display("FAIL oob_row got a=%h gr=%0d want a=00 gr=0", ascii_out, glyph_row);
    else passed++;
    h_addr = 10'(mx * CW + 3); v_addr = 10'(my * CH + 5);
    @(posedge clk); #1;
    total++;
    if (ascii_out !== exp_cell(mx, my))
      $display("FAIL cursor_cell got=%h want=%h", ascii_out, exp_cell(mx, my));
    else passed++;
  endtask

  task automatic test_backspace();
    int n;
    logic [7:0] a;
    logic [3:0] gc, gr;
    int h, v;
    do_reset();
    wait_ready(n);
    total++;
    if (n !== COLS * ROWS) $display("FAIL bs_reclear_cycles got=%0d want=%0d", n, COLS * ROWS);
    else passed++;
    for (int i = 0; i < COLS - 1; i++) send_key(8'h61);
    send_key(8'h7A);
    total++;
    if (cur_x !== 7'd0 || cur_y !== 5'd1) $display("FAIL bs_setup got=(%0d,%0d) want=(0,1)", cur_x, cur_y);
    else passed++;
    send_key(8'h08);
    total++;
    if (cur_x !== 7'(COLS - 1) || cur_y !== 5'd0)
      $display("FAIL bs_wrap_cursor got=(%0d,%0d) want=(%0d,0)", cur_x, cur_y, COLS - 1);
    else passed++;
    read_cell(COLS - 1, 0, a, gc, gr, h, v);
    total++;
    if (a !== exp_cell(COLS - 1, 0)) $display("FAIL bs_blank got=%h want=%h", a, exp_cell(COLS - 1, 0));
    else passed++;
    read_cell(COLS - 2, 0, a, gc, gr, h, v);
    total++;
    if (a !== 8'h61) $display("FAIL bs_neighbour got=%h want=61", a);
    else passed++;
    for (int i = 0; i < COLS - 1; i++) send_key(8'h08);
    send_key(8'h08);
    total++;
    if (cur_x !== 7'd0 || cur_y !== 5'd0) $display("FAIL bs_origin got=(%0d,%0d) want=(0,0)", cur_x, cur_y);
    else passed++;
    read_cell(1, 0, a, gc, gr, h, v);
    total++;
    if (a !== exp_cell(1, 0)) $display("FAIL bs_row0 got=%h want=%h", a, exp_cell(1, 0));
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] k, a;
    logic [3:0] gc, gr;
    int r, h, v, c0, r0, bad, br, bc;
    logic [7:0] others [5];
    others = '{8'h00, 8'h1B, 8'h7F, 8'hFF, 8'h09};
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 70)      k = 8'($urandom_range(126, 32));
      else if (r < 78) k = 8'h0A;
      else if (r < 82) k = 8'h0D;
      else if (r < 92) k = 8'h08;
      else             k = others[$urandom_range(4)];
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
      send_key(k);
      total++;
      if (cur_x !== 7'(mx) || cur_y !== 5'(my))
        $display("FAIL rand_cursor key=%h got=(%0d,%0d) want=(%0d,%0d)", k, cur_x, cur_y, mx, my);
      else passed++;
      if (i % 20 == 0) begin
        c0 = $urandom_range(COLS - 1);
        r0 = $urandom_range(ROWS - 1);
        read_cell(c0, r0, a, gc, gr, h, v);
        total++;
        if (a !== exp_cell(c0, r0) || gc !== 4'(h % CW) || gr !== 4'(v % CH))
          $display("FAIL rand_read (%0d,%0d) got a=%h gc=%0d gr=%0d want a=%h gc=%0d gr=%0d",
                   c0, r0, a, gc, gr, exp_cell(c0, r0), h % CW, v % CH);
        else passed++;
      end
    end
    while (!key_ready) begin @(posedge clk); #1; end
    capture_screen();
    bad = 0; br = 0; bc = 0;
    for (int rr = 0; rr < ROWS; rr++)
      for (int c = 0; c < COLS; c++)
        if (got[rr][c] !== exp_cell(c, rr)) begin
          if (bad == 0) begin br = rr; bc = c; end
          bad++;
        end
    total++;
    if (bad != 0) $display("FAIL rand_screen bad_cells=%0d first(%0d,%0d) got=%h want=%h",
                           bad, bc, br, got[br][bc], exp_cell(bc, br));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_print();
    test_wrap();
    test_scroll();
    test_oob();
    test_backspace();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
